lemming_world: RTL and testbench
================================

Name: lemming_world

Overview:
- Environment model that drives a Lemmings walker FSM: consumes the walker's state outputs and produces `bump_left`, `bump_right` and `ground`.
- Holds a 1-D terrain height map, the lemming's column/altitude, and step, fall and dig timing.
- Sits beside the walker FSM in simulation/demo top levels; terrain is loaded through a small config write port.

Parameters:
- NCOL, 16, number of terrain columns (≥2).
- XW, 4, column index width, ≥ clog2(NCOL).
- HW, 4, height/altitude width.
- FLOOR_H, 2, reset height of every column (1..2^HW-1).
- START_X, 0, reset column of lemming.
- STEP_CYCLES, 4, cycles of continuous walking per one-column move (≥1).
- DIG_CYCLES, 3, cycles of continuous digging per one-layer removal (≥1).
- FALL_LIMIT, 3, max survivable fall distance in layers (LEMMING_SPLAT_EN only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- walk_left  in  1  walker state: walking left
- walk_right  in  1  walker state: walking right
- aaah  in  1  walker state: falling
- digging  in  1  walker state: digging
- cfg_we  in  1  terrain write strobe
- cfg_addr  in  XW  column to write
- cfg_height  in  HW  new column height (0 = bottomless pit)
- ground  out  1  lemming stands on terrain
- bump_left  out  1  obstacle immediately left
- bump_right  out  1  obstacle immediately right
- pos_x  out  XW  lemming column
- pos_y  out  HW  lemming altitude
- lost  out  1  sticky: lemming fell into pit

Behaviour:
- State registers: h[0..NCOL-1], x, y, step_cnt, dig_cnt, lost (plus fall_dist and splat with the optional feature).
- Reset (async, rst=1): all h = FLOOR_H; x = START_X; y = FLOOR_H; counters = 0; lost = 0.
- Resulting reset outputs: ground=1; bump_left = (START_X==0); bump_right = (START_X==NCOL-1).
- Outputs are combinational from registers only (Moore); no input-to-output path.
  - ground = (h[x]!=0) && (y==h[x]).
  - bump_left = (x==0) || (h[x-1] > y).
  - bump_right = (x==NCOL-1) || (h[x+1] > y).
- Inputs are assumed one-hot or all-zero. If more than one is high, priority is aaah > digging > walk_left > walk_right.
- Walking (walk_left, bump_left=0):
  - step_cnt increments each cycle.
  - At STEP_CYCLES-1: x ← x-1, step_cnt ← 0, y unchanged.
  - A move onto a lower column leaves ground=0 next cycle; the walker then falls.
  - walk_right mirrors this with x+1 and bump_right.
- Walking into a bump: no move; step_cnt ← 0.
- step_cnt also clears whenever walk_left/walk_right is low or the direction changes. No partial credit carries over.
- Falling (aaah=1):
  - If y > h[x]: y ← y-1 every cycle.
  - If y == h[x] and h[x] != 0: hold (the walker lands next edge).
  - If h[x]==0 and y==0: hold, and lost ← 1 (sticky until rst).
  - y never underflows below 0.
- Digging (digging=1, ground=1):
  - dig_cnt increments each cycle.
  - At DIG_CYCLES-1: h[x] ← h[x]-1, y ← y-1 together, dig_cnt ← 0. ground stays 1 while h[x] > 0 after the decrement.
  - Removing the last layer (h[x] 1→0) gives y=0, ground=0; the walker falls into the pit.
  - dig_cnt clears when digging is low.
- Digging with ground=0: no effect.
- Config write (cfg_we=1) takes effect on the next clock edge: h[cfg_addr] ← cfg_height.
  - cfg_addr ≥ NCOL: ignored.
  - Write to the lemming's column with cfg_height > y: y ← cfg_height (lemming pushed up, ground=1).
  - cfg write and dig decrement on the same column in the same cycle: cfg wins; dig_cnt ← 0.
- No other arithmetic wraps; x is never moved past 0 or NCOL-1 because the bump is asserted there.

Optional Feature:
- Macro: LEMMING_SPLAT_EN.
- Enabled:
  - Adds output port `splat` (1 bit, sticky, reset 0).
  - fall_dist counts y decrements made while aaah=1 and clears when aaah=0.
  - A landing (aaah=1, y==h[x]!=0) with fall_dist > FALL_LIMIT sets splat.
  - While splat=1, x, y and h are frozen; bump/ground remain driven from the frozen state.
- Disabled: no splat port or fall_dist logic; all landings are survivable.

Test Plan:
- Reset with NCOL=16, START_X=0 → ground=1, bump_left=1, bump_right=0, pos_x=0, pos_y=2, lost=0.
- walk_right held 8 cycles on flat terrain → pos_x=2 after cycle 8. Then force walk_left for 3 cycles → pos_x stays 2 (step_cnt restarted).
- h[3]=5, lemming at x=2, y=2, walk_right → bump_right=1, pos_x stays 2.
- h[3]=0 (pit): walk_right from x=2 → x=3, ground=0. With aaah held: y 2→1→0, then lost=1 and stays 1.
- digging held at x=1, h=2: after 3 cycles h[1]=1, y=1, ground=1. After 6 cycles y=0, ground=0.
- LEMMING_SPLAT_EN, FALL_LIMIT=3: cfg h[5]=9, then h[5]=1 while standing at x=5; hold aaah → lands after 8 decrements, splat=1, pos frozen. With the macro off → no splat, walk resumes.

Source files
------------

// File: rtl/lemming_world.sv
// rtl/lemming_world.sv - Terrain, position, step/fall/dig timing environment for a Lemmings walker FSM
// Optional build macro LEMMING_SPLAT_EN adds the splat output (fatal fall freezes the world).
module lemming_world #(
   parameter int NCOL        = 16,
   parameter int XW          = 4,
   parameter int HW          = 4,
   parameter int FLOOR_H     = 2,
   parameter int START_X     = 0,
   parameter int STEP_CYCLES = 4,
   parameter int DIG_CYCLES  = 3
`ifdef LEMMING_SPLAT_EN
   , parameter int FALL_LIMIT = 3
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          walk_left,
   input  logic          walk_right,
   input  logic          aaah,
   input  logic          digging,
   input  logic          cfg_we,
   input  logic [XW-1:0] cfg_addr,
   input  logic [HW-1:0] cfg_height,
   output logic          ground,
   output logic          bump_left,
   output logic          bump_right,
   output logic [XW-1:0] pos_x,
   output logic [HW-1:0] pos_y,
   output logic          lost
`ifdef LEMMING_SPLAT_EN
   , output logic        splat
`endif
);

   localparam int SCW = $clog2(STEP_CYCLES + 1);
   localparam int DCW = $clog2(DIG_CYCLES + 1);
   localparam logic [XW-1:0] X_MAX = XW'(NCOL - 1);

   logic [HW-1:0]  h [NCOL];
   logic [XW-1:0]  x;
   logic [HW-1:0]  y;
   logic [SCW-1:0] step_cnt;
   logic           step_dir;
   logic [DCW-1:0] dig_cnt;

   logic [XW-1:0]  idx_l, idx_r;
   logic [HW-1:0]  hx, hl, hr;
   logic           walking, dir_r, walk_bump, step_done;
   logic [SCW-1:0] step_eff;
   logic           dig_act, dig_done;
   logic           cfg_ok, cfg_here;
   logic           fall_step, pit;
   logic           frozen;

   // Neighbour indices are clamped at the edges; the edge itself forces the bump.
   always_comb begin
      idx_l      = (x == '0)    ? x : x - 1'b1;
      idx_r      = (x == X_MAX) ? x : x + 1'b1;
      hx         = h[x];
      hl         = h[idx_l];
      hr         = h[idx_r];
      ground     = (hx != '0) && (y == hx);
      bump_left  = (x == '0)    || (hl > y);
      bump_right = (x == X_MAX) || (hr > y);
      pos_x      = x;
      pos_y      = y;
   end

   // Priority aaah > digging > walk_left > walk_right.
   always_comb begin
      walking   = !aaah && !digging && (walk_left || walk_right);
      dir_r     = !walk_left;
      walk_bump = dir_r ? bump_right : bump_left;
      step_eff  = (dir_r != step_dir) ? '0 : step_cnt;
      step_done = walking && !walk_bump && (step_eff == SCW'(STEP_CYCLES - 1));
      dig_act   = !aaah && digging && ground;
      dig_done  = dig_act && (dig_cnt == DCW'(DIG_CYCLES - 1));
      cfg_ok    = cfg_we && (int'(cfg_addr) < NCOL);
      cfg_here  = cfg_ok && (cfg_addr == x);
      fall_step = aaah && (y > hx);
      pit       = aaah && (hx == '0) && (y == '0);
   end

`ifdef LEMMING_SPLAT_EN
   logic [HW-1:0] fall_dist;
   logic          land;

   assign land   = aaah && (hx != '0) && (y == hx);
   assign frozen = splat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fall_dist <= '0;
         splat     <= 1'b0;
      end else begin
         if (!aaah)
            fall_dist <= '0;
         else if (fall_step && (fall_dist != '1))
            fall_dist <= fall_dist + 1'b1;
         if (land && (int'(fall_dist) > FALL_LIMIT))
            splat <= 1'b1;
      end
   end
`else
   assign frozen = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCOL; i++)
            h[i] <= HW'(FLOOR_H);
         x        <= XW'(START_X);
         y        <= HW'(FLOOR_H);
         step_cnt <= '0;
         step_dir <= 1'b0;
         dig_cnt  <= '0;
         lost     <= 1'b0;
      end else begin
         if (!walking || walk_bump || step_done)
            step_cnt <= '0;
         else
            step_cnt <= step_eff + 1'b1;
         if (walking)
            step_dir <= dir_r;

         if (!dig_act || dig_done)
            dig_cnt <= '0;
         else
            dig_cnt <= dig_cnt + 1'b1;

         if (pit)
            lost <= 1'b1;

         if (!frozen) begin
            if (step_done)
               x <= dir_r ? x + 1'b1 : x - 1'b1;
            // A terrain write to the lemming's column overrides a same-cycle dig.
            if (dig_done && !cfg_here)
               h[x] <= hx - 1'b1;
            if (cfg_ok)
               h[cfg_addr] <= cfg_height;
            if (cfg_here && (cfg_height > y))
               y <= cfg_height;
            else if (fall_step)
               y <= y - 1'b1;
            else if (dig_done && !cfg_here)
               y <= y - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lemming_world.sv
// tb/tb_lemming_world.sv - Table, directed and randomized model-based bench for lemming_world
// Build with LEMMING_SPLAT_EN defined to exercise the splat variant.
module tb_lemming_world;

   localparam int NCOL    = 16;
   localparam int STEP    = 4;
   localparam int DIG     = 3;
   localparam int FLOOR_H = 2;
   localparam int FALL_LIMIT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       walk_left, walk_right, aaah, digging, cfg_we;
   logic [3:0] cfg_addr, cfg_height;
   logic       ground, bump_left, bump_right, lost;
   logic [3:0] pos_x, pos_y;
`ifdef LEMMING_SPLAT_EN
   logic       splat;
`endif

   int checks = 0;
   int errors = 0;

   lemming_world dut (
      .clk(clk), .rst(rst),
      .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah), .digging(digging),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_height(cfg_height),
      .ground(ground), .bump_left(bump_left), .bump_right(bump_right),
      .pos_x(pos_x), .pos_y(pos_y), .lost(lost)
`ifdef LEMMING_SPLAT_EN
      , .splat(splat)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic wl, wr, aa, dg, we;
      int   addr, hgt;
      int   ex, ey, eg, ebl, ebr, el;
   } vec_t;
   vec_t tbl[$];

   // Reference world: plain integers, walking tracked as a run length of same-direction cycles.
   int mh[NCOL];
   int mx, my, mrun, mdir, mdig, mlost, mfall, msplat;

   function automatic int pack(int px, int py, int g, int bl, int br, int l);
      return (px << 8) | (py << 4) | (g << 3) | (bl << 2) | (br << 1) | l;
   endfunction

   function automatic int dut_pack();
      return pack(int'(pos_x), int'(pos_y), int'(ground), int'(bump_left), int'(bump_right), int'(lost));
   endfunction

   function automatic int m_ground();
      return (mh[mx] != 0 && my == mh[mx]) ? 1 : 0;
   endfunction
   function automatic int m_bl();
      if (mx == 0) return 1;
      return (mh[mx-1] > my) ? 1 : 0;
   endfunction
   function automatic int m_br();
      if (mx == NCOL - 1) return 1;
      return (mh[mx+1] > my) ? 1 : 0;
   endfunction
   function automatic int m_pack();
      return pack(mx, my, m_ground(), m_bl(), m_br(), mlost);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCOL; i++) mh[i] = FLOOR_H;
      mx = 0; my = FLOOR_H; mrun = 0; mdir = 0; mdig = 0;
      mlost = 0; mfall = 0; msplat = 0;
   endtask

   task automatic model_step(input logic wl, wr, aa, dg, we, input int addr, hgt);
      int  nx, ny, d;
      bit  dig_ev;
      int  g, bl, br;
      g = m_ground(); bl = m_bl(); br = m_br();
      nx = mx; ny = my; dig_ev = 0;
      if (aa) begin
         mrun = 0; mdig = 0;
         if (my > mh[mx]) begin
            ny = my - 1;
            mfall++;
         end else if (mh[mx] != 0) begin
`ifdef LEMMING_SPLAT_EN
            if (mfall > FALL_LIMIT) msplat = 1;
`endif
         end else begin
            mlost = 1;
         end
      end else begin
         mfall = 0;
         if (dg) begin
            mrun = 0;
            if (g == 1) begin
               mdig++;
               if (mdig == DIG) begin dig_ev = 1; mdig = 0; end
            end else mdig = 0;
         end else if (wl || wr) begin
            mdig = 0;
            d = wl ? 0 : 1;
            if (d != mdir) mrun = 0;
            mdir = d;
            if ((d == 1) ? br : bl) mrun = 0;
            else begin
               mrun++;
               if (mrun == STEP) begin
                  nx = (d == 1) ? mx + 1 : mx - 1;
                  mrun = 0;
               end
            end
         end else begin
            mrun = 0; mdig = 0;
         end
      end
      if (msplat == 1 && aa && my == mh[mx] && mh[mx] != 0 && nx == mx && ny == my) begin
         // landing cycle that sets splat still applies a same-cycle terrain write
      end
      if (dig_ev && !(we && addr == mx)) begin
         mh[mx] = mh[mx] - 1;
         ny = my - 1;
      end
      if (we && addr < NCOL) begin
         mh[addr] = hgt;
         if (addr == mx && hgt > my) ny = hgt;
      end
      mx = nx; my = ny;
   endtask

   task automatic model_apply(input logic wl, wr, aa, dg, we, input int addr, hgt);
      int sh[NCOL];
      int sx, sy;
      bit was_splat;
      was_splat = (msplat == 1);
      sh = mh; sx = mx; sy = my;
      model_step(wl, wr, aa, dg, we, addr, hgt);
      if (was_splat) begin
         mh = sh; mx = sx; my = sy;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic wl, wr, aa, dg, we, input int addr, hgt);
      walk_left = wl; walk_right = wr; aaah = aa; digging = dg;
      cfg_we = we; cfg_addr = addr[3:0]; cfg_height = hgt[3:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      idle_in();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("reset_outputs", dut_pack(), pack(0, FLOOR_H, 1, 1, 0, 0));
`ifdef LEMMING_SPLAT_EN
      chk("reset_splat", int'(splat), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic add(input logic wl, wr, aa, dg, we, input int addr, hgt,
                      input int ex, ey, eg, ebl, ebr, el);
      vec_t v;
      v.wl = wl; v.wr = wr; v.aa = aa; v.dg = dg; v.we = we;
      v.addr = addr; v.hgt = hgt;
      v.ex = ex; v.ey = ey; v.eg = eg; v.ebl = ebl; v.ebr = ebr; v.el = el;
      tbl.push_back(v);
   endtask

   task automatic walk(input int n, input bit right, input int ex, input string nm);
      for (int i = 0; i < n; i++) begin
         drive(!right, right, 0, 0, 0, 0, 0);
         tick();
      end
      chk(nm, int'(pos_x), ex);
   endtask

   initial begin
      idle_in();
      // Table built from flat terrain at reset: x=0, y=2, every h=2.
      for (int i = 1; i <= 8; i++)
         add(0, 1, 0, 0, 0, 0, 0, (i < 4) ? 0 : (i < 8) ? 1 : 2, 2, 1, (i < 4) ? 1 : 0, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 3, 5, 2, 2, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 2, 2, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 3, 0, 2, 2, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 1, 3, 2, 3, 2, 1, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 3, 2, 1, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 3, 2, 1, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 1, 1, 1);
      add(0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 1, 1, 1);
      add(0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 1, 1, 1);
      add(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 1, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 1, 1);

      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].wl, tbl[i].wr, tbl[i].aa, tbl[i].dg, tbl[i].we, tbl[i].addr, tbl[i].hgt);
         tick();
         chk($sformatf("vec%0d", i), dut_pack(),
             pack(tbl[i].ex, tbl[i].ey, tbl[i].eg, tbl[i].ebl, tbl[i].ebr, tbl[i].el));
      end

      // Terrain write lands on the same edge as a dig decrement: write wins, dig restarts.
      do_reset();
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 0, 0, 1, 1, 0, 4);
      tick();
      chk("dig_cfg_conflict", dut_pack(), pack(0, 4, 1, 1, 0, 0));
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0, 0, 0); tick(); end
      chk("dig_restart_partial", int'(pos_y), 4);
      drive(0, 0, 0, 1, 0, 0, 0); tick();
      chk("dig_after_conflict", dut_pack(), pack(0, 3, 1, 1, 0, 0));

      // Direction changes discard partial step credit.
      do_reset();
      walk(20, 1, 5, "walk20_right");
      walk(2, 1, 5, "partial_right");
      walk(3, 0, 5, "left_after_change");
      walk(1, 0, 4, "left_4th_moves");
      walk(3, 1, 4, "right_after_change");
      walk(1, 1, 5, "right_4th_moves");

      // Long fall onto a one-layer column.
      drive(0, 0, 0, 0, 1, 6, 1); tick();
      drive(0, 0, 0, 0, 1, 5, 9); tick();
      chk("push_up", dut_pack(), pack(5, 9, 1, 0, 0, 0));
      drive(0, 0, 0, 0, 1, 5, 1); tick();
      chk("floor_removed", int'(ground), 0);
      for (int i = 0; i < 8; i++) begin drive(0, 0, 1, 0, 0, 0, 0); tick(); end
      chk("fell_8", dut_pack(), pack(5, 1, 1, 1, 0, 0));
      drive(0, 0, 1, 0, 0, 0, 0); tick();
`ifdef LEMMING_SPLAT_EN
      chk("splat_set", int'(splat), 1);
      walk(4, 1, 5, "frozen_after_splat");
      chk("splat_sticky", int'(splat), 1);
`else
      chk("landed", int'(ground), 1);
      walk(4, 1, 6, "walk_resumes");
      chk("walk_resumes_y", int'(pos_y), 1);
`endif

      // Randomized run against the reference world.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic wl, wr, aa, dg, we;
         int r, addr, hgt;
         r = $urandom_range(0, 99);
         wl = (r >= 30 && r < 55); wr = (r < 30); aa = (r >= 55 && r < 70); dg = (r >= 70 && r < 85);
         if ($urandom_range(0, 19) == 0) begin
            wl = wl | $urandom_range(0, 1); aa = aa | $urandom_range(0, 1);
         end
         we = ($urandom_range(0, 99) < 8);
         addr = $urandom_range(0, NCOL - 1);
         hgt = $urandom_range(0, 6);
         drive(wl, wr, aa, dg, we, addr, hgt);
         model_apply(wl, wr, aa, dg, we, addr, hgt);
         tick();
         chk($sformatf("rand%0d", c), dut_pack(), m_pack());
`ifdef LEMMING_SPLAT_EN
         chk($sformatf("rand_splat%0d", c), int'(splat), msplat);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
